img2col_window_pu: RTL and testbench

//  Parametrised img2col processing unit: assembles KxK convolution windows from

---
 rtl/img2col_window_pu.sv | 155 +++++++++++++++
 tb/tb_img2col_window_pu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/img2col_window_pu.sv
// img2col processing unit: builds KxK windows from streamed column data,
// optionally preloaded with K-1 neighbour columns, and hands them to the MAC array.

module img2col_window_lane #(
    parameter int K    = 5,
    parameter int LANE = 0,
    parameter int IW   = 3
) (
    input  logic [IW-1:0] e,
    output logic          en,
    output logic [IW-1:0] row
);
    int sum;

    always_comb begin
        sum = int'(e) + LANE;
        en  = (sum < K);
        row = IW'(sum);
    end
endmodule

module img2col_window_pu #(
    parameter int DATA_W   = 16,
    parameter int K        = 5,
    parameter int WR_LANES = 2,
    parameter int STRIDE   = 1,
    parameter int CNT_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CNT_W-1:0]             row_len,
    input  logic                         nb_in_valid,
    input  logic [K*(K-1)*DATA_W-1:0]    nb_in,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [WR_LANES*DATA_W-1:0]   wr_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [K*K*DATA_W-1:0]        out_win,
    output logic                         nb_out_valid,
    output logic [K*(K-1)*DATA_W-1:0]    nb_out,
    output logic                         busy,
    output logic                         done
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;
    state_t state, state_nxt;

    // window store indexed [col][row]; packing matches the out_win layout
    logic [K-1:0][K-1:0][DATA_W-1:0] win;
    logic [IW-1:0]                   col_ptr, e;
    logic [CNT_W-1:0]                win_cnt, len;
    logic [WR_LANES-1:0]             lane_en;
    logic [WR_LANES-1:0][IW-1:0]     lane_row;
    logic                            beat, hs, col_last, row_last;

    for (genvar l = 0; l < WR_LANES; l++) begin : g_lane
        img2col_window_lane #(.K(K), .LANE(l), .IW(IW)) u_lane (
            .e   (e),
            .en  (lane_en[l]),
            .row (lane_row[l])
        );
    end

    assign beat     = wr_valid && (state == FILL);
    assign hs       = out_ready && (state == EMIT);
    assign col_last = (int'(e) + WR_LANES) >= K;
    assign row_last = (win_cnt == len - CNT_W'(1));
    assign out_win  = win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: if (start && row_len != '0) state_nxt = FILL;
            FILL: begin
                wr_ready = 1'b1;
                if (beat && col_last && col_ptr == IW'(K-1)) state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (hs) state_nxt = row_last ? IDLE : FILL;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win          <= '0;
            col_ptr      <= '0;
            e            <= '0;
            win_cnt      <= '0;
            len          <= '0;
            nb_out       <= '0;
            nb_out_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done         <= 1'b0;
            nb_out_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (row_len == '0) begin
                        done <= 1'b1;
                    end else begin
                        len     <= row_len;
                        win_cnt <= '0;
                        e       <= '0;
                        if (nb_in_valid) begin
                            win[K-2:0] <= nb_in;
                            col_ptr    <= IW'(K-1);
                        end else begin
                            col_ptr <= '0;
                        end
                    end
                end
                FILL: if (beat) begin
                    for (int l = 0; l < WR_LANES; l++)
                        if (lane_en[l]) win[col_ptr][lane_row[l]] <= wr_data[l*DATA_W +: DATA_W];
                    if (col_last) begin
                        e       <= '0;
                        col_ptr <= (col_ptr == IW'(K-1)) ? '0 : col_ptr + IW'(1);
                    end else begin
                        e <= e + IW'(WR_LANES);
                    end
                end
                EMIT: if (hs) begin
                    win_cnt <= win_cnt + CNT_W'(1);
                    if (win_cnt == '0) begin
                        nb_out       <= win[K-1:1];
                        nb_out_valid <= 1'b1;
                    end
                    if (row_last) begin
                        done    <= 1'b1;
                        win_cnt <= '0;
                    end else begin
                        // surviving columns slide left; the vacated tail is refilled
                        for (int c = 0; c < K - STRIDE; c++) win[c] <= win[c + STRIDE];
                        col_ptr <= IW'(K - STRIDE);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_img2col_window_pu.sv
// Scoreboard bench for img2col_window_pu: a STRIDE=1 and a STRIDE=2 instance
// share stimulus; the selected instance is checked.

module tb_img2col_window_pu;
    localparam int DATA_W = 16, K = 5, WR_LANES = 2, CNT_W = 8;
    localparam int WW = K*K*DATA_W, NW = K*(K-1)*DATA_W;

    logic clk = 0, rst = 1, start = 0, nb_in_valid = 0, wr_valid = 0, out_ready = 0;
    logic [CNT_W-1:0] row_len = '0;
    logic [NW-1:0] nb_in = '0;
    logic [WR_LANES*DATA_W-1:0] wr_data = '0;
    logic sel = 0;

    logic wr_ready_a, out_valid_a, nbv_a, busy_a, done_a;
    logic wr_ready_b, out_valid_b, nbv_b, busy_b, done_b;
    logic [WW-1:0] out_win_a, out_win_b;
    logic [NW-1:0] nb_out_a, nb_out_b;

    logic s_wr_ready, s_out_valid, s_nbv, s_busy, s_done;
    logic [WW-1:0] s_out_win;
    logic [NW-1:0] s_nb_out;
    assign s_wr_ready  = sel ? wr_ready_b  : wr_ready_a;
    assign s_out_valid = sel ? out_valid_b : out_valid_a;
    assign s_nbv       = sel ? nbv_b       : nbv_a;
    assign s_busy      = sel ? busy_b      : busy_a;
    assign s_done      = sel ? done_b      : done_a;
    assign s_out_win   = sel ? out_win_b   : out_win_a;
    assign s_nb_out    = sel ? nb_out_b    : nb_out_a;

    int n_cmp = 0, n_err = 0, done_cnt = 0, nbv_cnt = 0;
    logic [WW-1:0] exp_q[$];

    always #5 clk = ~clk;

    img2col_window_pu #(.DATA_W(DATA_W), .K(K), .WR_LANES(WR_LANES), .STRIDE(1), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst(rst), .start(start), .row_len(row_len), .nb_in_valid(nb_in_valid),
        .nb_in(nb_in), .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_data(wr_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_win(out_win_a),
        .nb_out_valid(nbv_a), .nb_out(nb_out_a), .busy(busy_a), .done(done_a));

    img2col_window_pu #(.DATA_W(DATA_W), .K(K), .WR_LANES(WR_LANES), .STRIDE(2), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst(rst), .start(start), .row_len(row_len), .nb_in_valid(nb_in_valid),
        .nb_in(nb_in), .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_data(wr_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_win(out_win_b),
        .nb_out_valid(nbv_b), .nb_out(nb_out_b), .busy(busy_b), .done(done_b));

    // scoreboard: every accepted window is popped and compared
    always @(negedge clk) begin
        if (!rst) begin
            if (s_out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL win_unexpected got=%h", s_out_win);
                end else if (s_out_win !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL win got=%h exp=%h", s_out_win, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (s_done) done_cnt++;
            if (s_nbv)  nbv_cnt++;
        end
    end

    function automatic logic [WW-1:0] win_seq(input int base);
        logic [WW-1:0] w;
        for (int i = 0; i < K*K; i++) w[i*DATA_W +: DATA_W] = 16'(base + i);
        return w;
    endfunction

    function automatic logic [WW-1:0] win_nb(input int nbbase, input int newbase);
        logic [WW-1:0] w;
        for (int i = 0; i < K*K; i++)
            w[i*DATA_W +: DATA_W] = (i < K*(K-1)) ? 16'(nbbase + i) : 16'(newbase + i - K*(K-1));
        return w;
    endfunction

    function automatic logic [NW-1:0] nb_seq(input int base);
        logic [NW-1:0] w;
        for (int i = 0; i < K*(K-1); i++) w[i*DATA_W +: DATA_W] = 16'(base + i);
        return w;
    endfunction

    task automatic do_reset();
        rst = 1; start = 0; wr_valid = 0; out_ready = 0; nb_in_valid = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        done_cnt = 0; nbv_cnt = 0;
    endtask

    task automatic do_start(input int len, input bit nbv, input int nbbase);
        start = 1; row_len = CNT_W'(len); nb_in_valid = nbv; nb_in = nb_seq(nbbase);
        @(posedge clk); #1;
        start = 0; nb_in_valid = 0;
    endtask

    task automatic send_beat(input int a, input int b);
        bit ok = 0;
        wr_data = {16'(b), 16'(a)};
        wr_valid = 1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (s_wr_ready) ok = 1;
            @(posedge clk); #1;
        end
        wr_valid = 0;
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL beat_timeout got=wr_ready_low exp=accept");
        end
    endtask

    task automatic send_col(input int base);
        send_beat(base, base + 1);
        send_beat(base + 2, base + 3);
        send_beat(base + 4, 16'hBEEF);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !s_busy) ok = 1;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bit ok;
        sel = 0;
        do_reset();
        @(negedge clk);
        ok = !s_busy && !s_out_valid && !s_wr_ready && !s_done && !s_nbv && s_out_win == '0 && s_nb_out == '0;
        n_cmp++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL reset_outputs got=%b exp=1", ok); end
    endtask

    task automatic test_no_neighbour();
        bit ok;
        sel = 0; do_reset(); out_ready = 1;
        exp_q.push_back(win_seq(1));
        exp_q.push_back(win_seq(6));
        do_start(2, 0, 0);
        for (int c = 0; c < K; c++) send_col(1 + c*K);
        send_col(26);
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL t1_drain got=%0d exp=0", exp_q.size()); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL t1_done got=%0d exp=1", done_cnt); end
        n_cmp++; if (nbv_cnt !== 1) begin n_err++; $display("FAIL t1_nbv got=%0d exp=1", nbv_cnt); end
        n_cmp++; if (s_nb_out !== nb_seq(6)) begin n_err++; $display("FAIL t1_nb_out got=%h exp=%h", s_nb_out, nb_seq(6)); end
    endtask

    task automatic test_neighbour();
        bit ok;
        sel = 0; do_reset(); out_ready = 0;
        exp_q.push_back(win_nb(100, 1));
        do_start(1, 1, 100);
        send_beat(1, 2); send_beat(3, 4);
        n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL t2_early got=%b exp=0", s_out_valid); end
        send_beat(5, 16'hBEEF);
        n_cmp++; if (s_out_valid !== 1'b1) begin n_err++; $display("FAIL t2_latency got=%b exp=1", s_out_valid); end
        out_ready = 1;
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1 || done_cnt !== 1) begin n_err++; $display("FAIL t2_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [WW-1:0] w;
        sel = 0; do_reset(); out_ready = 0;
        w = win_nb(200, 51);
        exp_q.push_back(w);
        do_start(1, 1, 200);
        send_beat(51, 52); send_beat(53, 54); send_beat(55, 16'hBEEF);
        wr_valid = 1; wr_data = 32'h7777_7777;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            n_cmp++;
            if (!(s_out_valid === 1'b1 && s_out_win === w && s_wr_ready === 1'b0)) begin
                n_err++;
                $display("FAIL t3_stall cyc=%0d got=v%b r%b win=%h exp=v1 r0 win=%h", t, s_out_valid, s_wr_ready, s_out_win, w);
            end
        end
        @(posedge clk); #1;
        wr_valid = 0; out_ready = 1;
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1 || done_cnt !== 1) begin n_err++; $display("FAIL t3_release got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        sel = 0; out_ready = 1; done_cnt = 0;
        do_start(1, 0, 0);
        for (int b = 0; b < 7; b++) send_beat(500 + 2*b, 501 + 2*b);
        #2 rst = 1;
        #1;
        ok = !s_busy && !s_out_valid && !s_wr_ready && !s_done && !s_nbv && s_out_win == '0 && s_nb_out == '0;
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL t4_async_reset got=%b exp=1", ok); end
        @(posedge clk); #1 rst = 0;
        done_cnt = 0;
        exp_q.push_back(win_seq(300));
        do_start(1, 0, 0);
        for (int c = 0; c < K; c++) send_col(300 + c*K);
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1 || done_cnt !== 1) begin n_err++; $display("FAIL t4_refill got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_stride2();
        bit ok;
        sel = 1; do_reset(); out_ready = 1;
        exp_q.push_back(win_seq(1));
        exp_q.push_back(win_seq(11));
        do_start(2, 0, 0);
        for (int c = 0; c < K; c++) send_col(1 + c*K);
        send_col(26); send_col(31);
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1 || done_cnt !== 1) begin n_err++; $display("FAIL t5_done got=%0d exp=1", done_cnt); end
        n_cmp++; if (nbv_cnt !== 1) begin n_err++; $display("FAIL t5_nbv got=%0d exp=1", nbv_cnt); end
        n_cmp++; if (s_nb_out !== nb_seq(6)) begin n_err++; $display("FAIL t5_nb_out got=%h exp=%h", s_nb_out, nb_seq(6)); end
    endtask

    task automatic test_zero_len_and_busy_start();
        bit ok;
        sel = 0; do_reset(); out_ready = 1;
        do_start(0, 0, 0);
        n_cmp++; if (s_done !== 1'b1 || s_busy !== 1'b0) begin n_err++; $display("FAIL t6_zero_done got=d%b b%b exp=d1 b0", s_done, s_busy); end
        @(posedge clk); #1;
        n_cmp++; if (s_done !== 1'b0 || s_out_valid !== 1'b0) begin n_err++; $display("FAIL t6_zero_after got=d%b v%b exp=d0 v0", s_done, s_out_valid); end
        done_cnt = 0;
        exp_q.push_back(win_nb(400, 41));
        do_start(1, 1, 400);
        send_beat(41, 42);
        do_start(0, 0, 900);
        n_cmp++; if (s_busy !== 1'b1 || done_cnt !== 0) begin n_err++; $display("FAIL t6_busy_start got=b%b d%0d exp=b1 d0", s_busy, done_cnt); end
        send_beat(43, 44); send_beat(45, 16'hBEEF);
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1 || done_cnt !== 1) begin n_err++; $display("FAIL t6_complete got=%0d exp=1", done_cnt); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_no_neighbour();
        test_neighbour();
        test_backpressure();
        test_reset_mid_fill();
        test_stride2();
        test_zero_len_and_busy_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
